// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer that sits beside the single-cycle ALU.
// Multiplies finish in two cycles; divides and remainders use a 32-step restoring divider.
module muldiv_seq #(
  parameter logic [4:0] OP_MUL    = 5'b00010,
  parameter logic [4:0] OP_MULH   = 5'b00011,
  parameter logic [4:0] OP_MULHSU = 5'b00100,
  parameter logic [4:0] OP_MULHU  = 5'b00101,
  parameter logic [4:0] OP_DIV    = 5'b00110,
  parameter logic [4:0] OP_DIVU   = 5'b00111,
  parameter logic [4:0] OP_REM    = 5'b01000,
  parameter logic [4:0] OP_REMU   = 5'b01001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  alu_ctl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  localparam int DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DATA_W-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [DATA_W-1:0] ALL_ONES = 32'hFFFF_FFFF;

  logic [1:0]        state;
  logic [4:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic [4:0]        cnt;
  logic              neg_quo_q;
  logic              neg_rem_q;

  // Two's complement negate when requested; also used to take magnitudes.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Architectural results for divisor zero and signed overflow.
  function automatic logic [DATA_W-1:0] special_res(input logic is_rem, input logic zero,
                                                    input logic [DATA_W-1:0] dividend);
    if (zero) return is_rem ? dividend : ALL_ONES;
    return is_rem ? 32'd0 : INT_MIN;
  endfunction

  // Request decode
  logic req_mul;
  logic req_div;
  logic req_signed;
  logic req_rem;
  logic a_neg;
  logic b_neg;
  logic div_zero;
  logic div_ovf;
  logic accept;

  always_comb begin
    req_mul    = (alu_ctl == OP_MUL) || (alu_ctl == OP_MULH) ||
                 (alu_ctl == OP_MULHSU) || (alu_ctl == OP_MULHU);
    req_div    = (alu_ctl == OP_DIV) || (alu_ctl == OP_DIVU) ||
                 (alu_ctl == OP_REM) || (alu_ctl == OP_REMU);
    req_signed = (alu_ctl == OP_DIV) || (alu_ctl == OP_REM);
    req_rem    = (alu_ctl == OP_REM) || (alu_ctl == OP_REMU);
    a_neg      = req_signed & op_a[DATA_W-1];
    b_neg      = req_signed & op_b[DATA_W-1];
    div_zero   = (op_b == 32'd0);
    div_ovf    = req_signed && (op_a == INT_MIN) && (op_b == ALL_ONES);
    accept     = (state == S_IDLE) && start && !flush && (req_mul || req_div);
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign stall = ((state == S_IDLE) && start && (req_mul || req_div)) ||
                 (state == S_MUL) || (state == S_DIV);

  // Multiply datapath: operands widened per op so one signed multiplier covers all four.
  logic                     mul_a_sgn;
  logic                     mul_b_sgn;
  logic signed [2*DATA_W-1:0] mul_a_ext;
  logic signed [2*DATA_W-1:0] mul_b_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]        mul_res;

  always_comb begin
    mul_a_sgn = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    mul_b_sgn = (op_q == OP_MULH);
    mul_a_ext = {{DATA_W{mul_a_sgn & a_q[DATA_W-1]}}, a_q};
    mul_b_ext = {{DATA_W{mul_b_sgn & b_q[DATA_W-1]}}, b_q};
    prod      = mul_a_ext * mul_b_ext;
    mul_res   = (op_q == OP_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
  end

  // Restoring divide step: shift {rem, quo} left, trial-subtract the divisor magnitude.
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] trial;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] div_res;

  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    trial   = shifted[DATA_W-1:0] - dvs_q;
    rem_nxt = fits ? trial : shifted[DATA_W-1:0];
    quo_nxt = {quo_q[DATA_W-2:0], fits};
    if ((op_q == OP_REM) || (op_q == OP_REMU))
      div_res = neg_if(rem_nxt, neg_rem_q);
    else
      div_res = neg_if(quo_nxt, neg_quo_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= alu_ctl;
            a_q  <= op_a;
            b_q  <= op_b;
            if (req_mul) begin
              state <= S_MUL;
            end else if (div_zero || div_ovf) begin
              result <= special_res(req_rem, div_zero, op_a);
              state  <= S_DONE;
            end else begin
              quo_q     <= neg_if(op_a, a_neg);
              dvs_q     <= neg_if(op_b, b_neg);
              rem_q     <= '0;
              cnt       <= '0;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              state     <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            result <= mul_res;
            state  <= S_DONE;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result <= div_res;
              state  <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M operations (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) that the decoder marks with ALU control codes 00010–01001.
- It latches operands when `start` is asserted.
- Multiplies take a fixed two-cycle path; divides and remainders run a 32-iteration restoring divider.
- It raises `stall` to freeze the pipeline while busy and pulses `done` with the result for write-back.
- It sits beside the single-cycle ALU in the execute stage.

## Interface
- `OP_MUL`, default 5'b00010, alu_ctl code for mul (low 32 bits of the product)
- `OP_MULH`, default 5'b00011, signed×signed, high 32 bits
- `OP_MULHSU`, default 5'b00100, signed rs1 × unsigned rs2, high 32 bits
- `OP_MULHU`, default 5'b00101, unsigned×unsigned, high 32 bits
- `OP_DIV` / `OP_DIVU` / `OP_REM` / `OP_REMU`, defaults 5'b00110 / 00111 / 01000 / 01001
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `alu_ctl`  in  5  operation code, sampled with `start`
- `op_a`  in  32  rs1 value
- `op_b`  in  32  rs2 value
- `flush`  in  1  synchronous abort of the operation in flight
- `busy`  out  1  high whenever state != IDLE
- `stall`  out  1  combinational pipeline freeze request
- `done`  out  1  one-cycle pulse marking `result` valid
- `result`  out  32  result register; holds its value until the next accepted operation completes

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Accept:** `start` in IDLE with `alu_ctl` matching one of the eight codes.
  - On accept, latch `op_a`, `op_b` and the op, then go to the next state.
  - `start` with any other code is ignored: stay in IDLE, no stall.
  - `start` outside IDLE is ignored.
- **IDLE → MUL:** for the four multiply codes.
- **MUL → DONE:** form the 64-bit product from the latched operands, sign-extending each to 33 bits according to the op. Load `result` with product[31:0] for mul, or product[63:32] for mulh/mulhsu/mulhu.
- **IDLE → DONE directly (special divide cases):**
  - Divisor 0: div/divu give 0xFFFFFFFF; rem/remu give the dividend.
  - div/rem with op_a = 0x80000000 and op_b = 0xFFFFFFFF: div gives 0x80000000, rem gives 0.
- **IDLE → DIV:** all other divide codes.
  - Load the magnitudes (absolute values for the signed ops) and clear the 5-bit iteration counter.
- **DIV:** each cycle runs one restoring step.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from the 33-bit remainder.
  - If the difference is non-negative, keep it and set the quotient LSB.
  - After the step with counter = 31, go to DONE and load `result`:
    - div: quotient negated if sign(a) ^ sign(b).
    - divu: unsigned quotient.
    - rem: remainder negated if sign(a).
    - remu: unsigned remainder.
- **DONE:** `done` = 1 for this cycle only, then return to IDLE unconditionally.
- **stall** = (state == IDLE & start & valid code) | state == MUL | state == DIV.
  - `stall` is low in DONE, so the pipeline advances on the `done` cycle.
- **flush:** in MUL or DIV, go to IDLE next edge with no `done` pulse and `result` unchanged. In IDLE it suppresses accept. In DONE it is ignored (the pulse completes).
- **Priority:** rst > flush > start.
- **Reset values:** state IDLE, counter 0, `result` 0, `busy` 0, `done` 0, `stall` 0. Operand/internal registers clear to 0.

## Timing
- Let the accept edge be the end of cycle N.
- Multiply: MUL in N+1, DONE (`done` = 1) in N+2. Latency is 2 cycles.
- Normal divide: DIV in N+1..N+32, DONE in N+33. Latency is 33 cycles.
- Special divide: DONE in N+1. Latency is 1 cycle.
- `stall` is high in cycle N (combinational on `start`) and through the last MUL/DIV cycle.
- Back-to-back: a new `start` is accepted in the cycle after DONE at the earliest. Minimum issue interval is 3 cycles for mul and 34 cycles for div.
- `rst` asserted mid-operation: IDLE and all outputs at reset values on the next edge; no `done`.

## Test plan
- **mul:** start with OP_MUL, a = 0xFFFFFFFE (−2), b = 3 → `done` at N+2, result 0xFFFFFFFA. mulhu with the same operands → 0x00000002. mulh → 0xFFFFFFFF. mulhsu with a = −1, b = 0xFFFFFFFF → 0xFFFFFFFF.
- **div/rem signs:** div a = −7, b = 2 → `done` at N+33, result 0xFFFFFFFD (−3). rem → 0xFFFFFFFF (−1). divu a = 100, b = 7 → 14. remu → 2. `stall` high for exactly 33 cycles (N..N+32).
- **Special cases:** div by 0 with a = 5 → 0xFFFFFFFF at N+1. remu by 0 → 5. div 0x80000000 / 0xFFFFFFFF → 0x80000000 at N+1. rem of the same operands → 0.
- **Flush/reset mid-op:** flush at N+10 of a div → IDLE next edge, no `done`, `result` keeps its old value. A following mul completes normally. `rst` at N+5 → all outputs reach reset values.
- **Ignored requests:** `start` with alu_ctl = 5'b00000 → no stall, `busy` stays 0. `start` during DIV → ignored, and the original result is still produced at N+33.
- **Back-to-back:** mul, then mul re-asserted on the DONE cycle → the second is ignored; the same request asserted on the following cycle is accepted and its `done` arrives 2 cycles later.
